// File: rtl/tiny_pattern_generator.sv
// tiny_pattern_generator: serial pattern source, MSB first, div+1 clocks per bit; TPG_LOOP_COUNT_EN adds loop_count.
module tiny_pattern_generator #(
    parameter int PATTERN_BITS = 8,
    parameter int DIV_WIDTH    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    input  logic       cfg_bit,
    input  logic       start,
    input  logic       stop,
    input  logic       one_shot,
    output logic       data_out,
    output logic       busy,
    output logic       bit_strobe,
    output logic       rising_pulse,
    output logic       falling_pulse,
    output logic       done
`ifdef TPG_LOOP_COUNT_EN
    ,
    output logic [7:0] loop_count
`endif
);
    localparam int CFG_W = DIV_WIDTH + PATTERN_BITS;
    localparam int IW = PATTERN_BITS > 1 ? $clog2(PATTERN_BITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(PATTERN_BITS - 1);
    localparam logic [IW-1:0] ONE_I = IW'(1);
    localparam logic [DIV_WIDTH-1:0] ONE_D = DIV_WIDTH'(1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                  state_q, state_d;
    logic [CFG_W-1:0]        cfg_q, cfg_d;
    logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    os_q, os_d;
    logic                    data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    strobe_q, strobe_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;
    logic                    done_q, done_d;
    logic [DIV_WIDTH-1:0]    div;
    logic [PATTERN_BITS-1:0] pat;
`ifdef TPG_LOOP_COUNT_EN
    logic [7:0]              loop_q, loop_d;
    assign loop_count = loop_q;
`endif
    assign div = cfg_q[CFG_W-1:PATTERN_BITS];
    assign pat = cfg_q[PATTERN_BITS-1:0];
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        os_d     = os_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
`ifdef TPG_LOOP_COUNT_EN
        loop_d   = loop_q;
`endif
        if (state_q == IDLE) begin
            cfg_d = cfg_valid ? {cfg_q[CFG_W-2:0], cfg_bit} : cfg_q;
            if (start && !stop) begin
                state_d  = RUN;
                os_d     = one_shot;
                idx_d    = LAST;
                cnt_d    = div;
                data_d   = pat[PATTERN_BITS-1];
                strobe_d = 1'b1;
`ifdef TPG_LOOP_COUNT_EN
                loop_d   = 8'd0;
`endif
            end
        end else if (stop) begin
            state_d = IDLE;
            data_d  = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE_D;
        end else begin
            idx_d = idx_q != '0 ? idx_q - ONE_I : LAST;
            cnt_d = div;
`ifdef TPG_LOOP_COUNT_EN
            loop_d = (idx_q == '0 && loop_q != 8'hFF) ? loop_q + 8'd1 : loop_q;
`endif
            if (idx_q == '0 && os_q) begin
                state_d = IDLE;
                data_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                data_d   = pat[idx_d];
                strobe_d = 1'b1;
            end
        end
        busy_d = state_d == RUN;
        rise_d = data_d & ~data_q;
        fall_d = ~data_d & data_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            os_q     <= 1'b0;
            data_q   <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef TPG_LOOP_COUNT_EN
            loop_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            os_q     <= os_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            done_q   <= done_d;
`ifdef TPG_LOOP_COUNT_EN
            loop_q   <= loop_d;
`endif
        end
    end
    assign data_out      = data_q;
    assign busy          = busy_q;
    assign bit_strobe    = strobe_q;
    assign rising_pulse  = rise_q;
    assign falling_pulse = fall_q;
    assign done          = done_q;
endmodule
